finish_aggregator: RTL and testbench
====================================

# finish_aggregator

Collects the per-processing-unit finish flags produced by the `finish_bit` capture registers and decides when an iteration has terminated. Termination requires every flag to be set on a configurable number of consecutive cycles. On termination the block reports a done handshake to the host-side controller, counts completed iterations, and issues the one-cycle `clear_finish` pulse that re-arms every `finish_bit` instance for the next iteration.

## Interface
- `NUM_PU`, 4: number of processing units and `finish_bit` instances aggregated.
- `STABLE_CYCLES`, 16: number of consecutive all-ones samples required to declare termination. A value of 0 is treated as 1.
- `ITER_W`, 16: width of the iteration counter.
- `TIMEOUT_CYCLES`, 65536: watchdog limit in cycles. Used only with `FINISH_AGG_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request from the host to begin a run. Honoured only in IDLE.
- `finish_in`  in  NUM_PU  `finish_reg` outputs of the `finish_bit` instances. These are already registered and are used without a synchronizer.
- `clear_finish`  out  1  wired to `clear_finish_reg` of every `finish_bit` instance.
- `busy`  out  1  high in any state other than IDLE.
- `done_valid`  out  1  termination detected. Held until acknowledged.
- `done_ack`  in  1  host acknowledge of `done_valid`.
- `done_last`  in  1  sampled together with `done_ack`. 1 ends the run; 0 starts the next iteration.
- `iter_count`  out  ITER_W  number of iterations completed in the current run.
- `timeout`  out  1  the watchdog forced the current done.

## Operation
- The FSM is Moore-type, with states IDLE, CLEAR, RUN and DONE. All outputs come from registers or decode the state only.
- Reset values: state = IDLE; `clear_finish`, `busy`, `done_valid` and `timeout` = 0; `iter_count` = 0; stability counter = 0; watchdog counter = 0.
- IDLE:
  - `start` = 1 → CLEAR. At the same edge `iter_count` goes to 0.
  - `start` in any other state is ignored.
- CLEAR:
  - `clear_finish` = 1 for exactly this one cycle.
  - Next edge → RUN unconditionally, with the stability counter and watchdog counter set to 0.
- RUN:
  - Each edge where `finish_in` is all ones, the stability counter increments.
  - Any edge where any bit is 0 resets the stability counter to 0.
  - At the edge where the counter reaches `STABLE_CYCLES`: → DONE, and `iter_count` increments. `iter_count` saturates at all ones and does not wrap.
- DONE:
  - `done_valid` = 1 for the whole state.
  - `finish_in` is ignored.
  - `done_valid & done_ack` with `done_last` = 1 → IDLE.
  - `done_valid & done_ack` with `done_last` = 0 → CLEAR.
  - `done_ack` outside DONE is ignored.
- Stability counter width is `$clog2(STABLE_CYCLES+1)`. It never exceeds `STABLE_CYCLES`.
- Lost-set hazard: in `finish_bit`, clear has priority over set. A processing unit that pulses `set_finish` only during the CLEAR cycle loses that set. Processing units hold `set_finish` until they see `clear_finish`, or re-assert it after.
- Reset mid-operation returns immediately to IDLE with all outputs at their reset values. `clear_finish` is not pulsed.

## Timing
- Clear-to-RUN latency: `clear_finish` is high in cycle C. The `finish_bit` registers read 0 in cycle C+1, which is the first RUN cycle, so no blanking is needed.
- Termination latency: all-ones is first sampled at edge E and stays set. `done_valid` rises at edge E+STABLE_CYCLES-1, visible the cycle after that edge.
  - With `STABLE_CYCLES` = 1, `done_valid` is high in the cycle after the first all-ones sample.
- A bit that drops and recovers restarts the count from the edge where it is set again.
- Acknowledge: `done_valid` falls on the edge that samples `done_ack`. With `done_last` = 0, `clear_finish` is high in the following cycle.
- Minimum iteration period is 2 + `STABLE_CYCLES` cycles, plus the host acknowledge time.

## Configuration
- `FINISH_AGG_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in RUN.
  - On reaching `TIMEOUT_CYCLES` without termination: → DONE with `timeout` = 1, and `iter_count` increments.
  - `timeout` clears on the acknowledge edge.
  - If termination and timeout occur on the same edge, termination wins and `timeout` stays 0.
- `FINISH_AGG_TIMEOUT_EN` undefined:
  - No watchdog logic is built.
  - `timeout` is constant 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset release, then `start` pulse:
  - `clear_finish` high for exactly one cycle and `busy` = 1.
  - Hold `finish_in` = 4'b1111 from then on.
  - Required: `done_valid` after 16 samples, `iter_count` = 1.
- Glitch restart: set `finish_in` to all ones, drop bit 2 for one cycle after 10 samples, then restore. Required: `done_valid` rises 16 samples after the restore, not before.
- Multi-iteration: acknowledge with `done_last` = 0 three times, then with `done_last` = 1.
  - Required: one `clear_finish` pulse after each of the first three acknowledges.
  - Required: `iter_count` = 4, ending in IDLE with `busy` = 0.
- Ignored inputs: `start` during RUN and `done_ack` during RUN. Required: no state change.
- Corner cases:
  - `ITER_W` = 2 run through 5 iterations. Required: `iter_count` saturates at 3.
  - Assert `reset` while in DONE. Required: all outputs at their reset values at once, and no `clear_finish` pulse.
- With `FINISH_AGG_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 100: hold `finish_in` = 4'b0111. Required: `done_valid` and `timeout` both high after 100 RUN cycles, and `timeout` = 0 after the acknowledge.

Source files
------------

// File: rtl/finish_aggregator.sv
// Aggregates per-PU finish flags, declares termination after STABLE_CYCLES all-ones samples,
// and sequences the clear / done handshake. Optional watchdog: define FINISH_AGG_TIMEOUT_EN.
module finish_aggregator #(
  parameter int NUM_PU         = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int ITER_W         = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_PU-1:0] finish_in,
  output logic              clear_finish,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ack,
  input  logic              done_last,
  output logic [ITER_W-1:0] iter_count,
  output logic              timeout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A configured value of 0 behaves exactly like 1.
  localparam int STABLE_EFF = (STABLE_CYCLES < 1) ? 1 : STABLE_CYCLES;
  localparam int STAB_W     = $clog2(STABLE_EFF + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_EFF - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_EFF);

  state_t              r_state;
  state_t              w_next_state;
  logic [STAB_W-1:0]   r_stab;
  logic [ITER_W-1:0]   r_iter;
  logic                w_all_ones;
  logic                w_stable_hit;
  logic                w_wdog_hit;
  logic                w_ack;

  // Done handshake: done_valid is held high for the whole DONE state; the transfer
  // happens on the edge where done_valid & done_ack are both high, done_last picks the exit.
  assign w_all_ones   = &finish_in;
  assign w_stable_hit = (r_state == S_RUN) && w_all_ones && (r_stab == STAB_LAST);
  assign w_ack        = (r_state == S_DONE) && done_ack;

`ifdef FINISH_AGG_TIMEOUT_EN
  localparam int TO_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
  localparam int WD_W   = $clog2(TO_EFF + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_EFF - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TO_EFF);

  logic [WD_W-1:0] r_wdog;
  logic            r_timeout;

  assign w_wdog_hit = (r_state == S_RUN) && (r_wdog == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_wdog <= '0;
      end else if (r_state == S_RUN && r_wdog != WD_MAX) begin
        r_wdog <= r_wdog + 1'b1;
      end
      // Genuine termination on the same edge takes precedence over the watchdog.
      if (w_wdog_hit && !w_stable_hit) begin
        r_timeout <= 1'b1;
      end else if (w_ack) begin
        r_timeout <= 1'b0;
      end
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_wdog_hit   = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_CLEAR;
      S_CLEAR: w_next_state = S_RUN;
      S_RUN:   if (w_stable_hit || w_wdog_hit) w_next_state = S_DONE;
      S_DONE:  if (done_ack) w_next_state = done_last ? S_IDLE : S_CLEAR;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    clear_finish = 1'b0;
    busy         = 1'b0;
    done_valid   = 1'b0;
    case (r_state)
      S_CLEAR: begin clear_finish = 1'b1; busy = 1'b1; end
      S_RUN:   busy = 1'b1;
      S_DONE:  begin done_valid = 1'b1; busy = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stab <= '0;
      r_iter <= '0;
    end else begin
      if (r_state == S_CLEAR) begin
        r_stab <= '0;
      end else if (r_state == S_RUN) begin
        if (!w_all_ones) begin
          r_stab <= '0;
        end else if (r_stab != STAB_MAX) begin
          r_stab <= r_stab + 1'b1;
        end
      end
      if (r_state == S_IDLE && start) begin
        r_iter <= '0;
      end else if ((w_stable_hit || w_wdog_hit) && r_iter != {ITER_W{1'b1}}) begin
        r_iter <= r_iter + 1'b1;
      end
    end
  end

  assign iter_count = r_iter;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_finish_aggregator.sv
// Directed bench for finish_aggregator: main instance (defaults) plus a 2-bit iteration
// counter instance with STABLE_CYCLES = 1 for saturation and minimum latency.
module tb_finish_aggregator;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  finish_in;
  logic        clear_finish, busy, done_valid, done_ack, done_last, timeout;
  logic [15:0] iter_count;
  logic [1:0]  dbg_state;

  logic        start2;
  logic [3:0]  finish_in2;
  logic        clear2, busy2, done2, ack2, last2, timeout2;
  logic [1:0]  iter2;
  logic [1:0]  dbg_state2;

  int n_cmp = 0;
  int n_err = 0;

  finish_aggregator #(.NUM_PU(4), .STABLE_CYCLES(16), .ITER_W(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .start(start), .finish_in(finish_in),
    .clear_finish(clear_finish), .busy(busy), .done_valid(done_valid),
    .done_ack(done_ack), .done_last(done_last), .iter_count(iter_count),
    .timeout(timeout), .dbg_state(dbg_state)
  );

  finish_aggregator #(.NUM_PU(4), .STABLE_CYCLES(1), .ITER_W(2), .TIMEOUT_CYCLES(100)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .finish_in(finish_in2),
    .clear_finish(clear2), .busy(busy2), .done_valid(done2),
    .done_ack(ack2), .done_last(last2), .iter_count(iter2),
    .timeout(timeout2), .dbg_state(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish_in = '0; done_ack = 1'b0; done_last = 1'b0;
    start2 = 1'b0; finish_in2 = '0; ack2 = 1'b0; last2 = 1'b0;
    #2;
    chk("rst_clear", clear_finish, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_timeout", timeout, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // First iteration: 16 all-ones samples, with start/ack pulsed during RUN.
    start = 1'b1;
    tick();
    start = 1'b0; finish_in = 4'hF;
    chk("clear_pulse", clear_finish, 1);
    chk("clear_busy", busy, 1);
    chk("clear_iter", iter_count, 0);
    tick();
    chk("clear_one_cycle", clear_finish, 0);
    chk("run_state", dbg_state, ST_RUN);
    for (int i = 0; i < 15; i++) begin
      if (i == 5) begin start = 1'b1; done_ack = 1'b1; end
      tick();
      if (i == 5) begin
        start = 1'b0; done_ack = 1'b0;
        chk("ignore_start_ack_state", dbg_state, ST_RUN);
        chk("ignore_start_ack_clear", clear_finish, 0);
      end
    end
    chk("it1_not_early", done_valid, 0);
    tick();
    chk("it1_done", done_valid, 1);
    chk("it1_iter", iter_count, 1);
    finish_in = 4'h0;
    tick();
    chk("done_hold", done_valid, 1);
    chk("done_hold_iter", iter_count, 1);

    // Ack with done_last=0, then glitch on bit 2 after 10 samples.
    finish_in = 4'hF; done_ack = 1'b1; done_last = 1'b0;
    tick();
    done_ack = 1'b0;
    chk("ack1_done_fall", done_valid, 0);
    chk("ack1_clear", clear_finish, 1);
    tick();
    repeat (10) tick();
    finish_in = 4'b1011;
    tick();
    finish_in = 4'hF;
    repeat (15) tick();
    chk("glitch_not_early", done_valid, 0);
    tick();
    chk("glitch_done", done_valid, 1);
    chk("it2_iter", iter_count, 2);

    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("ack2_clear", clear_finish, 1);
    tick();
    repeat (15) tick();
    chk("it3_not_early", done_valid, 0);
    tick();
    chk("it3_done", done_valid, 1);
    chk("it3_iter", iter_count, 3);

    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    chk("ack3_clear", clear_finish, 1);
    tick();
    repeat (16) tick();
    chk("it4_done", done_valid, 1);
    chk("it4_iter", iter_count, 4);

    done_ack = 1'b1; done_last = 1'b1;
    tick();
    done_ack = 1'b0; done_last = 1'b0;
    chk("last_busy", busy, 0);
    chk("last_done", done_valid, 0);
    chk("last_clear", clear_finish, 0);
    chk("last_iter", iter_count, 4);
    tick();
    chk("last_no_clear", clear_finish, 0);

    // New run restarts the count, then reset lands in DONE.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_iter", iter_count, 0);
    chk("restart_clear", clear_finish, 1);
    tick();
    repeat (16) tick();
    chk("run2_done", done_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_done_state", dbg_state, ST_IDLE);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_busy", busy, 0);
    chk("rst_done_iter", iter_count, 0);
    chk("rst_done_clear", clear_finish, 0);
    tick();
    reset = 1'b0;
    chk("rst_hold_clear", clear_finish, 0);
    tick();
    chk("rst_after_clear", clear_finish, 0);
    chk("rst_after_busy", busy, 0);

    // Never-terminating run: watchdog build times out, default build waits.
    finish_in = 4'b0111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
`ifdef FINISH_AGG_TIMEOUT_EN
    repeat (99) tick();
    chk("wd_not_early", done_valid, 0);
    chk("wd_not_early_to", timeout, 0);
    tick();
    chk("wd_done", done_valid, 1);
    chk("wd_timeout", timeout, 1);
    chk("wd_iter", iter_count, 1);
    done_ack = 1'b1; done_last = 1'b1;
    tick();
    done_ack = 1'b0; done_last = 1'b0;
    chk("wd_ack_timeout", timeout, 0);
    chk("wd_ack_busy", busy, 0);
`else
    repeat (120) tick();
    chk("nowd_done", done_valid, 0);
    chk("nowd_timeout", timeout, 0);
    chk("nowd_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    // Saturating 2-bit counter, one-sample termination.
    finish_in2 = 4'hF;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("sat_clear", clear2, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("sat_run_not_done", done2, 0);
      tick();
      chk("sat_done", done2, 1);
      chk("sat_iter", iter2, (k > 3) ? 3 : k);
      ack2 = 1'b1; last2 = (k == 5);
      tick();
      ack2 = 1'b0; last2 = 1'b0;
    end
    chk("sat_end_busy", busy2, 0);
    chk("sat_end_iter", iter2, 3);
    chk("sat_timeout", timeout2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
